sdf_out_collector: RTL and testbench

- Receiving end of the SDF NTT/INTT pipeline output interface.
- Captures `sdf_out` words into a 2^address_width-entry buffer at the bit-reversed/scrambled `out_address` supplied by `sdf_top` whenever `data_valid` is high.
- Once the frame is complete (or `done_tick` arrives), streams the coefficients out in natural index order on a valid/ready interface.
- Replaces the bench-side capture memory with synthesizable logic between `sdf_top` and the downstream consumer (AXI wrapper / next polynomial stage).

---
 rtl/sdf_out_collector_pkg.sv | 20 ++
 rtl/sdf_out_collector_if.sv | 23 ++
 rtl/sdf_out_collector_coeff_buffer.sv | 38 +++
 rtl/sdf_out_collector.sv | 160 ++++++++++++++++
 tb/tb_sdf_out_collector.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sdf_out_collector_pkg.sv
// Shared definitions for the SDF output collector.
// - Default coefficient/address widths, kept equal to those of sdf_top.
// - Collector FSM state encoding.
// - poly_n(): polynomial size N = 2**address_width.
package sdf_out_collector_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  function automatic int poly_n(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sdf_out_collector_if.sv
// Natural-order coefficient stream from the collector to its consumer.
// Signals:
//   m_data  - coefficient word
//   m_index - natural index of m_data
//   m_valid - beat valid
//   m_last  - marks index N-1
//   m_ready - consumer accepts the beat
// Modports:
//   master - the collector side (drives data/valid)
//   slave  - the consumer side (drives ready)
interface sdf_out_collector_if #(
  parameter int data_width    = 32,
  parameter int address_width = 4
);
  logic [data_width-1:0]    m_data;
  logic [address_width-1:0] m_index;
  logic                     m_valid;
  logic                     m_last;
  logic                     m_ready;

  modport master (output m_data, m_index, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_index, m_valid, m_last, output m_ready);
endinterface

// File: rtl/sdf_out_collector_coeff_buffer.sv
// N x data_width coefficient store: one synchronous write port and one
// registered read port. The read register is reset; the array is not.
// Ports:
//   clk, rst          - clock, async active-high reset (read register only)
//   wr_en/addr/data   - write port
//   rd_en/rd_addr     - load rd_data from the addressed slot
//   rd_zero           - load 0 instead (slot was never filled this frame)
//   rd_data           - registered read data
module coeff_buffer #(
  parameter int data_width    = 32,
  parameter int address_width = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [address_width-1:0] wr_addr,
  input  logic [data_width-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [address_width-1:0] rd_addr,
  input  logic                     rd_zero,
  output logic [data_width-1:0]    rd_data
);
  localparam int N = 1 << address_width;

  logic [data_width-1:0] mem [N];
  logic [data_width-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= rd_zero ? '0 : mem[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/sdf_out_collector.sv
// Collects sdf_top output words written at scrambled addresses, then streams
// the frame out in natural index order on a valid/ready interface.
// Ports:
//   clk, rst             - clock, async active-high reset
//   sdf_out/out_address  - coefficient and destination slot, qualified by data_valid
//   done_tick            - end-of-transform pulse, ends a short frame early
//   clr_err              - clears the sticky error flags
//   m                    - natural-order output stream (master side)
//   accepting            - high while not draining
//   drain_done           - one-cycle pulse after the last beat is accepted
//   dup_err, incomplete_err, overrun_err - sticky error flags
module sdf_out_collector
  import sdf_out_collector_pkg::*;
#(
  parameter int data_width    = DATA_W_DEF,
  parameter int address_width = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [data_width-1:0]    sdf_out,
  input  logic [address_width-1:0] out_address,
  input  logic                     data_valid,
  input  logic                     done_tick,
  input  logic                     clr_err,
  sdf_out_collector_if.master      m,
  output logic                     accepting,
  output logic                     drain_done,
  output logic                     dup_err,
  output logic                     incomplete_err,
  output logic                     overrun_err
);
  localparam int N  = poly_n(address_width);
  localparam int CW = address_width + 1;
  localparam logic [address_width-1:0] LAST_IDX = address_width'(N - 1);
  localparam logic [CW-1:0]            FULL_CNT = CW'(N);

  state_e                   state_q, state_d;
  logic [N-1:0]             filled_q, filled_d;
  logic [CW-1:0]            count_q, count_d;
  logic [address_width-1:0] idx_q, idx_d;
  logic                     valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic                     dup_q, dup_d, inc_q, inc_d, ovr_q, ovr_d;
  logic                     wr_en, rd_en;
  logic [address_width-1:0] rd_addr;
  logic [data_width-1:0]    rd_data;

  always_comb begin
    state_d  = state_q;
    filled_d = filled_q;
    count_d  = count_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    dup_d    = dup_q & ~clr_err;
    inc_d    = inc_q & ~clr_err;
    ovr_d    = ovr_q & ~clr_err;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = idx_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (data_valid) begin
          wr_en = 1'b1;
          // filled is all-zero in IDLE, so a duplicate can only occur in COLLECT
          if (filled_q[out_address]) begin
            dup_d = 1'b1;
          end else begin
            filled_d[out_address] = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        if (state_q == ST_IDLE) begin
          if (data_valid) state_d = (count_d == FULL_CNT) ? ST_DRAIN : ST_COLLECT;
        end else if (count_d == FULL_CNT) begin
          // a done_tick on the completing write is not an error
          state_d = ST_DRAIN;
        end else if (done_tick) begin
          state_d = ST_DRAIN;
          inc_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (data_valid) ovr_d = 1'b1;
        if (!valid_q) begin
          // first DRAIN cycle: prime beat 0 (entry-edge write already landed)
          rd_en   = 1'b1;
          rd_addr = '0;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (N == 1);
        end else if (m.m_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + address_width'(1);
            rd_en   = 1'b1;
            rd_addr = idx_d;
            last_d  = (idx_d == LAST_IDX);
          end else begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b1;
            filled_d = '0;
            count_d  = '0;
            idx_d    = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      filled_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      dup_q    <= 1'b0;
      inc_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      filled_q <= filled_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      dup_q    <= dup_d;
      inc_q    <= inc_d;
      ovr_q    <= ovr_d;
    end
  end

  coeff_buffer #(.data_width(data_width), .address_width(address_width)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (out_address),
    .wr_data (sdf_out),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_zero (~filled_q[rd_addr]),
    .rd_data (rd_data)
  );

  assign m.m_data       = rd_data;
  assign m.m_index      = idx_q;
  assign m.m_valid      = valid_q;
  assign m.m_last       = last_q;
  assign accepting      = (state_q != ST_DRAIN);
  assign drain_done     = done_q;
  assign dup_err        = dup_q;
  assign incomplete_err = inc_q;
  assign overrun_err    = ovr_q;
endmodule

// File: tb/tb_sdf_out_collector.sv
module tb_sdf_out_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sdf_out;
  logic [3:0]  out_address;
  logic        data_valid, done_tick, clr_err;
  logic        accepting, drain_done, dup_err, incomplete_err, overrun_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_mem [16];

  sdf_out_collector_if #(.data_width(32), .address_width(4)) mif ();

  sdf_out_collector #(.data_width(32), .address_width(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .sdf_out        (sdf_out),
    .out_address    (out_address),
    .data_valid     (data_valid),
    .done_tick      (done_tick),
    .clr_err        (clr_err),
    .m              (mif),
    .accepting      (accepting),
    .drain_done     (drain_done),
    .dup_err        (dup_err),
    .incomplete_err (incomplete_err),
    .overrun_err    (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] brev(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    data_valid  = 1'b1;
    out_address = a;
    sdf_out     = d;
    step();
    data_valid  = 1'b0;
  endtask

  // Waits for the first beat, then accepts 16 beats at full rate against exp_mem.
  task automatic drain_check(input string tag);
    int w = 0;
    mif.m_ready = 1'b1;
    while (!mif.m_valid && w < 4) begin step(); w++; end
    chk({tag, "_valid"}, 32'(mif.m_valid), 1);
    for (int b = 0; b < 16; b++) begin
      chk($sformatf("%s_data%0d", tag, b), mif.m_data, exp_mem[b]);
      chk($sformatf("%s_idx%0d", tag, b), 32'(mif.m_index), b);
      chk($sformatf("%s_last%0d", tag, b), 32'(mif.m_last), (b == 15) ? 1 : 0);
      step();
    end
    chk({tag, "_done"}, 32'(drain_done), 1);
    chk({tag, "_vdrop"}, 32'(mif.m_valid), 0);
    step();
    chk({tag, "_done_pulse"}, 32'(drain_done), 0);
    mif.m_ready = 1'b0;
  endtask

  initial begin
    int exp_beat, cyc;
    logic stalled;
    logic [31:0] hold_data;
    logic [3:0]  hold_idx;
    logic [15:0] wmask;

    rst = 1'b1; sdf_out = '0; out_address = '0; data_valid = 1'b0;
    done_tick = 1'b0; clr_err = 1'b0; mif.m_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(mif.m_valid), 0);
    chk("rst_data", mif.m_data, 0);
    chk("rst_accepting", 32'(accepting), 1);
    chk("rst_errs", {29'd0, dup_err, incomplete_err, overrun_err}, 0);
    rst = 1'b0;
    step();

    // Full frame in bit-reversed order, slot value 100+slot
    for (int i = 0; i < 16; i++) exp_mem[i] = 100 + i;
    for (int i = 0; i < 16; i++) begin
      data_valid = 1'b1; out_address = brev(4'(i)); sdf_out = 100 + 32'(brev(4'(i)));
      step();
    end
    data_valid = 1'b0;
    chk("full_accepting", 32'(accepting), 0);
    chk("full_valid_early", 32'(mif.m_valid), 0);
    step();
    chk("full_valid_rise", 32'(mif.m_valid), 1);
    drain_check("full");
    chk("full_errs", {29'd0, dup_err, incomplete_err, overrun_err}, 0);

    // Same frame under backpressure (ready 1,0,0,...)
    for (int i = 0; i < 16; i++) wr(brev(4'(i)), 100 + 32'(brev(4'(i))));
    exp_beat = 0; cyc = 0; stalled = 1'b0; hold_data = '0; hold_idx = '0;
    while (exp_beat < 16 && cyc < 200) begin
      mif.m_ready = (cyc % 3 == 0);
      if (stalled) begin
        chk("bp_hold_data", mif.m_data, hold_data);
        chk("bp_hold_idx", 32'(mif.m_index), 32'(hold_idx));
      end
      if (mif.m_valid && mif.m_ready) begin
        chk("bp_data", mif.m_data, 100 + exp_beat);
        chk("bp_idx", 32'(mif.m_index), exp_beat);
        exp_beat++;
      end
      stalled = mif.m_valid && !mif.m_ready;
      hold_data = mif.m_data; hold_idx = mif.m_index;
      step();
      cyc++;
    end
    chk("bp_beats", exp_beat, 16);
    chk("bp_done", 32'(drain_done), 1);
    mif.m_ready = 1'b0;
    step();

    // Incomplete frame: 10 writes then done_tick
    wmask = '0;
    for (int i = 0; i < 10; i++) begin
      wr(brev(4'(i)), 200 + 32'(brev(4'(i))));
      wmask[brev(4'(i))] = 1'b1;
    end
    for (int i = 0; i < 16; i++) exp_mem[i] = wmask[i] ? 200 + i : 0;
    chk("inc_pre_err", 32'(incomplete_err), 0);
    done_tick = 1'b1; step(); done_tick = 1'b0;
    chk("inc_err", 32'(incomplete_err), 1);
    chk("inc_accepting", 32'(accepting), 0);
    drain_check("inc");
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("inc_clr", 32'(incomplete_err), 0);

    // Duplicate write to slot 3, then overrun during DRAIN
    wr(4'd3, 7000);
    chk("dup_pre", 32'(dup_err), 0);
    wr(4'd3, 7680);
    chk("dup_err", 32'(dup_err), 1);
    for (int a = 0; a < 16; a++) if (a != 3) wr(4'(a), 300 + a);
    for (int a = 0; a < 16; a++) exp_mem[a] = 300 + a;
    exp_mem[3] = 7680;
    chk("ovr_pre", 32'(overrun_err), 0);
    wr(4'd5, 9999);
    chk("ovr_err", 32'(overrun_err), 1);
    drain_check("dup");
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("dup_clr", 32'(dup_err), 0);
    chk("ovr_clr", 32'(overrun_err), 0);

    // 16th write coincides with done_tick
    for (int a = 0; a < 15; a++) wr(4'(a), 400 + a);
    done_tick = 1'b1; wr(4'd15, 415); done_tick = 1'b0;
    for (int a = 0; a < 16; a++) exp_mem[a] = 400 + a;
    chk("coin_inc", 32'(incomplete_err), 0);
    chk("coin_accepting", 32'(accepting), 0);
    drain_check("coin");

    // Reset at beat 5, then a fresh frame
    for (int a = 0; a < 16; a++) wr(4'(a), 500 + a);
    mif.m_ready = 1'b1;
    cyc = 0;
    while (!(mif.m_valid && mif.m_index == 4'd5) && cyc < 40) begin step(); cyc++; end
    chk("rm_beat5", mif.m_data, 505);
    rst = 1'b1;
    #1;
    chk("rm_valid", 32'(mif.m_valid), 0);
    chk("rm_data", mif.m_data, 0);
    chk("rm_idx", 32'(mif.m_index), 0);
    chk("rm_last", 32'(mif.m_last), 0);
    chk("rm_accepting", 32'(accepting), 1);
    step();
    rst = 1'b0;
    mif.m_ready = 1'b0;
    step();
    for (int i = 0; i < 16; i++) wr(brev(4'(i)), 600 + 32'(brev(4'(i))));
    for (int a = 0; a < 16; a++) exp_mem[a] = 600 + a;
    drain_check("post_rst");
    chk("post_errs", {29'd0, dup_err, incomplete_err, overrun_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
